// File: rtl/tick_debounce_pkg.sv
// Shared types, default widths and parameter legality helper for the tick_debounce block.
package tick_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_DN = 2'd1,
        DOWN   = 2'd2,
        DEB_UP = 2'd3
    } db_state_t;

    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_CNT_W        = 3;
    localparam int DEF_REPEAT_TICKS = 32;

    // True when the accept threshold is reachable by a saturating counter of cnt_w bits.
    function automatic bit stable_fits(input int stable, input int cnt_w);
        return (stable >= 1) && (stable < (1 << cnt_w));
    endfunction

endpackage

// File: rtl/tick_debounce_ch.sv
// One button channel: 2-flop synchronizer, slowen-gated debounce FSM, registered press/held.
// Auto-repeat while held is built only when TICK_DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_ch
    import tick_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic slowen,
    input  logic raw,
    output logic fire,
    output logic press,
    output logic held
);

    generate
        if (!stable_fits(STABLE_TICKS, CNT_W)) begin : g_bad_stable
            $error("debounce_ch: STABLE_TICKS does not fit in CNT_W");
        end
        if (REPEAT_TICKS < 1) begin : g_bad_repeat
            $error("debounce_ch: REPEAT_TICKS must be at least 1");
        end
    endgenerate

    localparam logic [CNT_W:0] LAST = (CNT_W + 1)'(STABLE_TICKS);

    logic             sync1;
    logic             s;
    db_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             done;
    logic             accept;
    logic             rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat = (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
    assign done    = (cnt_inc >= LAST);

    // With a threshold of one, the first disagreeing tick completes the transition.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        if (slowen) begin
            case (state)
                IDLE: begin
                    if (s) begin
                        if (STABLE_TICKS == 1) begin
                            state_n = DOWN;
                            accept  = 1'b1;
                        end else begin
                            state_n = DEB_DN;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                DEB_DN: begin
                    if (!s) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (done) begin
                        state_n = DOWN;
                        cnt_n   = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_n = cnt_sat;
                    end
                end
                DOWN: begin
                    if (!s) begin
                        if (STABLE_TICKS == 1) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DEB_UP;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                DEB_UP: begin
                    if (s) begin
                        state_n = DOWN;
                        cnt_n   = '0;
                    end else if (done) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_sat;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef TICK_DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);

    logic [RW-1:0] rep, rep_n;

    // Counts only ticks that stay in DOWN; entering or leaving DOWN restarts it.
    always_comb begin
        rep_n    = rep;
        rep_fire = 1'b0;
        if (slowen) begin
            if (state == DOWN && state_n == DOWN) begin
                if (rep + RW'(1) == REP_LAST) begin
                    rep_n    = '0;
                    rep_fire = 1'b1;
                end else begin
                    rep_n = rep + RW'(1);
                end
            end else begin
                rep_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rep <= '0;
        else     rep <= rep_n;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign fire = accept | rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            press <= fire;
            held  <= (state_n == DOWN) || (state_n == DEB_UP);
        end
    end

endmodule

// File: rtl/tick_debounce.sv
// Two-button debouncer driven by the divider's slowen strobe, with a same-cycle "both" flag.
// Optional auto-repeat: define TICK_DEBOUNCE_AUTOREPEAT_EN.
module tick_debounce
    import tick_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic slowen,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    output logic press_l,
    output logic press_r,
    output logic both,
    output logic held_l,
    output logic held_r
);

    logic fire_l;
    logic fire_r;

    debounce_ch #(
        .STABLE_TICKS (STABLE_TICKS),
        .CNT_W        (CNT_W),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch_l (
        .clk    (clk),
        .rst    (rst),
        .slowen (slowen),
        .raw    (btn_l_raw),
        .fire   (fire_l),
        .press  (press_l),
        .held   (held_l)
    );

    debounce_ch #(
        .STABLE_TICKS (STABLE_TICKS),
        .CNT_W        (CNT_W),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch_r (
        .clk    (clk),
        .rst    (rst),
        .slowen (slowen),
        .raw    (btn_r_raw),
        .fire   (fire_r),
        .press  (press_r),
        .held   (held_r)
    );

    // Registered from the same next-press terms so it lines up with the pulses.
    always_ff @(posedge clk) begin
        if (rst) both <= 1'b0;
        else     both <= fire_l & fire_r;
    end

endmodule

// File: tb/tb_tick_debounce.sv
// Bench for tick_debounce: scenario sequences plus random bouncing, checked every cycle
// against a run-length model of the debounce rules.
module tb_tick_debounce;

    localparam int ST = 4;
    localparam int CW = 3;
    localparam int RT = 3;
`ifdef TICK_DEBOUNCE_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    logic slowen;
    logic btn_l_raw;
    logic btn_r_raw;
    logic press_l;
    logic press_r;
    logic both;
    logic held_l;
    logic held_r;

    int errors = 0;
    int checks = 0;
    int slow_period = 256;
    int cnt_l = 0;
    int cnt_r = 0;
    int cnt_both = 0;

    // reference model state, index 0 = left, 1 = right
    bit m_sync1 [2];
    bit m_s     [2];
    bit m_held  [2];
    int m_run   [2];
    int m_rep   [2];
    bit m_press [2];
    bit m_both;

    tick_debounce #(
        .STABLE_TICKS (ST),
        .CNT_W        (CW),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slowen    (slowen),
        .btn_l_raw (btn_l_raw),
        .btn_r_raw (btn_r_raw),
        .press_l   (press_l),
        .press_r   (press_r),
        .both      (both),
        .held_l    (held_l),
        .held_r    (held_r)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // slowen strobe: one clk in every slow_period; period 1 means tied high
    initial begin
        int div_cnt;
        div_cnt = 0;
        slowen  = 1'b0;
        forever begin
            @(negedge clk);
            if (slow_period <= 1) begin
                slowen = 1'b1;
            end else begin
                div_cnt = (div_cnt + 1) % slow_period;
                slowen  = (div_cnt == 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a level flips once ST consecutive ticks disagree with it; a flip to 1 is a press.
    always @(posedge clk) begin
        bit raw_v [2];
        raw_v[0] = btn_l_raw;
        raw_v[1] = btn_r_raw;
        for (int c = 0; c < 2; c++) begin
            m_press[c] = 1'b0;
            if (rst) begin
                m_sync1[c] = 1'b0;
                m_s[c]     = 1'b0;
                m_held[c]  = 1'b0;
                m_run[c]   = 0;
                m_rep[c]   = 0;
            end else begin
                if (slowen) begin
                    if (m_s[c] != m_held[c]) begin
                        m_run[c] = m_run[c] + 1;
                        m_rep[c] = 0;
                        if (m_run[c] >= ST) begin
                            m_held[c]  = m_s[c];
                            m_run[c]   = 0;
                            m_press[c] = m_s[c];
                        end
                    end else begin
                        if (REP_ON && m_held[c] && m_run[c] == 0) begin
                            m_rep[c] = m_rep[c] + 1;
                            if (m_rep[c] == RT) begin
                                m_press[c] = 1'b1;
                                m_rep[c]   = 0;
                            end
                        end else begin
                            m_rep[c] = 0;
                        end
                        m_run[c] = 0;
                    end
                end
                m_s[c]     = m_sync1[c];
                m_sync1[c] = raw_v[c];
            end
        end
        m_both = m_press[0] & m_press[1];
    end

    // scoreboard: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("press_l", {31'd0, press_l}, {31'd0, m_press[0]});
            chk("press_r", {31'd0, press_r}, {31'd0, m_press[1]});
            chk("both",    {31'd0, both},    {31'd0, m_both});
            chk("held_l",  {31'd0, held_l},  {31'd0, m_held[0]});
            chk("held_r",  {31'd0, held_r},  {31'd0, m_held[1]});
            if (press_l === 1'b1) cnt_l++;
            if (press_r === 1'b1) cnt_r++;
            if (both === 1'b1)    cnt_both++;
        end
    end

    // driver tasks
    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            @(posedge clk);
            while (!slowen && guard < 1000) begin
                @(posedge clk);
                guard++;
            end
            if (!slowen) chk("tick_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cnt_l    = 0;
        cnt_r    = 0;
        cnt_both = 0;
    endtask

    initial begin
        rst       = 1'b1;
        btn_l_raw = 1'b0;
        btn_r_raw = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_press_l", {31'd0, press_l}, 32'd0);
        chk("reset_held_l",  {31'd0, held_l},  32'd0);
        chk("reset_both",    {31'd0, both},    32'd0);
        rst = 1'b0;

        // clean press with a slow strobe
        tick_wait(1);
        clear_counts();
        btn_l_raw = 1'b1;
        tick_wait(3);
        chk("t1_no_early_press", cnt_l, 32'd0);
        tick_wait(1);
        chk("t1_press_4th_tick", cnt_l, 32'd1);
        chk("t1_held", {31'd0, held_l}, 32'd1);
        tick_wait(2);
        chk("t1_single_pulse", cnt_l, 32'd1);
        chk("t1_no_right", cnt_r, 32'd0);
        chk("t1_no_both", cnt_both, 32'd0);
        btn_l_raw = 1'b0;
        tick_wait(5);
        chk("t1_released", {31'd0, held_l}, 32'd0);

        // bounce on the right button
        slow_period = 16;
        tick_wait(1);
        clear_counts();
        btn_r_raw = 1'b1;
        tick_wait(2);
        btn_r_raw = 1'b0;
        tick_wait(1);
        btn_r_raw = 1'b1;
        tick_wait(3);
        chk("t2_bounce_rejected", cnt_r, 32'd0);
        tick_wait(3);
        chk("t2_one_press", cnt_r, 32'd1);
        btn_r_raw = 1'b0;
        tick_wait(6);

        // simultaneous press
        clear_counts();
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        tick_wait(6);
        chk("t3_l", cnt_l, 32'd1);
        chk("t3_r", cnt_r, 32'd1);
        chk("t3_both", cnt_both, 32'd1);
        btn_l_raw = 1'b0;
        btn_r_raw = 1'b0;
        tick_wait(6);

        // reset in the middle of a debounce
        clear_counts();
        btn_l_raw = 1'b1;
        tick_wait(2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        chk("t4_no_press", cnt_l, 32'd0);
        chk("t4_held_low", {31'd0, held_l}, 32'd0);
        tick_wait(3);
        chk("t4_still_waiting", cnt_l, 32'd0);
        tick_wait(1);
        chk("t4_press_after_reset", cnt_l, 32'd1);

        // release and re-press
        btn_l_raw = 1'b0;
        tick_wait(6);
        clear_counts();
        btn_l_raw = 1'b1;
        tick_wait(6);
        btn_l_raw = 1'b0;
        tick_wait(3);
        chk("t5_held_3_low", {31'd0, held_l}, 32'd1);
        tick_wait(1);
        chk("t5_held_4_low", {31'd0, held_l}, 32'd0);
        btn_l_raw = 1'b1;
        tick_wait(6);
        chk("t5_two_presses", cnt_l, 32'd2);
        btn_l_raw = 1'b0;
        tick_wait(6);

        // slowen tied high, long hold (auto-repeat when built in)
        slow_period = 1;
        tick_wait(2);
        clear_counts();
        btn_l_raw = 1'b1;
        tick_wait(20);
        chk("t6_hold_pulses", cnt_l, REP_ON ? 32'd5 : 32'd1);
        btn_l_raw = 1'b0;
        tick_wait(3);
        clear_counts();
        tick_wait(10);
        chk("t6_stopped", cnt_l, 32'd0);
        chk("t6_released", {31'd0, held_l}, 32'd0);

        // random bouncing, strobe rates and occasional resets
        for (int seg = 0; seg < 4; seg++) begin
            slow_period = $urandom_range(1, 6);
            for (int i = 0; i < 800; i++) begin
                @(negedge clk);
                #1;
                if ($urandom_range(0, 11) == 0) btn_l_raw = ~btn_l_raw;
                if ($urandom_range(0, 11) == 0) btn_r_raw = ~btn_r_raw;
                rst = ($urandom_range(0, 299) == 0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
